// File: rtl/tpu_job_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : tpu_job_dispatcher_if
//  Purpose  : Host job, per-core handshake and completion report bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface tpu_job_dispatcher_if #(
    parameter int DIM_W  = 4,
    parameter int NCORE  = 2,
    parameter int CYC_W  = 16,
    parameter int QDEPTH = 4
);
    localparam int c_id_w  = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam int c_cnt_w = $clog2(QDEPTH) + 1;

    logic                     job_valid;
    logic                     job_ready;
    logic [DIM_W-1:0]         job_m;
    logic [DIM_W-1:0]         job_n;
    logic [DIM_W-1:0]         job_k;
    logic [NCORE-1:0]         core_start;
    logic [NCORE*DIM_W-1:0]   core_m;
    logic [NCORE*DIM_W-1:0]   core_n;
    logic [NCORE*DIM_W-1:0]   core_k;
    logic [NCORE-1:0]         core_done;
    logic                     done;
    logic [c_id_w-1:0]        done_id;
    logic [CYC_W-1:0]         done_cycles;
    logic                     err_zero;
    logic [c_cnt_w-1:0]       q_count;
    logic                     idle;

    modport master (
        output job_valid, job_m, job_n, job_k, core_done,
        input  job_ready, core_start, core_m, core_n, core_k,
               done, done_id, done_cycles, err_zero, q_count, idle
    );

    modport slave (
        input  job_valid, job_m, job_n, job_k, core_done,
        output job_ready, core_start, core_m, core_n, core_k,
               done, done_id, done_cycles, err_zero, q_count, idle
    );
endinterface
`default_nettype wire

// File: rtl/tpu_job_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tpu_job_dispatcher
//  Purpose  : Queues (m,n,k) jobs and dispatches them to NCORE TPU cores,
//             reporting each completion with core id and cycle count.
//  Revision : 1.0 - initial release
// ============================================================================
module tpu_job_dispatcher #(
    parameter int DIM_W  = 4,
    parameter int QDEPTH = 4,
    parameter int NCORE  = 2,
    parameter int CYC_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    tpu_job_dispatcher_if.slave  bus
);
    localparam int                 c_ptr_w   = $clog2(QDEPTH);
    localparam int                 c_id_w    = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam logic [c_ptr_w:0]   c_full    = (c_ptr_w + 1)'(QDEPTH);
    localparam logic [CYC_W-1:0]   c_cyc_max = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } core_state_t;

    core_state_t        r_state [NCORE];
    logic [CYC_W-1:0]   r_cyc   [NCORE];
    logic [DIM_W-1:0]   r_cm    [NCORE];
    logic [DIM_W-1:0]   r_cn    [NCORE];
    logic [DIM_W-1:0]   r_ck    [NCORE];
    logic               r_start [NCORE];

    logic [DIM_W-1:0]   r_qm [QDEPTH];
    logic [DIM_W-1:0]   r_qn [QDEPTH];
    logic [DIM_W-1:0]   r_qk [QDEPTH];
    logic [c_ptr_w-1:0] r_wp;
    logic [c_ptr_w-1:0] r_rp;
    logic [c_ptr_w:0]   r_count;
    logic               r_err;

    logic               r_done;
    logic [c_id_w-1:0]  r_done_id;
    logic [CYC_W-1:0]   r_done_cyc;

    logic               w_empty;
    logic               w_full;
    logic               w_zero;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [NCORE-1:0]   w_is_idle;
    logic [NCORE-1:0]   w_disp_sel;
    logic [NCORE-1:0]   w_rep_sel;
    logic               w_rep_any;
    logic [c_id_w-1:0]  w_rep_id;
    logic [CYC_W-1:0]   w_rep_cyc;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_full);
    assign w_zero   = (bus.job_m == '0) || (bus.job_n == '0) || (bus.job_k == '0);
    assign w_accept = bus.job_valid && !w_full;
    assign w_push   = w_accept && !w_zero;
    assign w_pop    = |w_disp_sel;

    // Walk from the top index down so the lowest matching core wins.
    always_comb begin
        w_is_idle  = '0;
        w_disp_sel = '0;
        w_rep_sel  = '0;
        w_rep_any  = 1'b0;
        w_rep_id   = '0;
        w_rep_cyc  = '0;
        for (int i = NCORE - 1; i >= 0; i--) begin
            w_is_idle[i] = (r_state[i] == S_IDLE);
            if ((r_state[i] == S_IDLE) && !w_empty) begin
                w_disp_sel    = '0;
                w_disp_sel[i] = 1'b1;
            end
            if (r_state[i] == S_DONE) begin
                w_rep_sel    = '0;
                w_rep_sel[i] = 1'b1;
                w_rep_any    = 1'b1;
                w_rep_id     = c_id_w'(i);
                w_rep_cyc    = r_cyc[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qm[r_wp] <= bus.job_m;
            r_qn[r_wp] <= bus.job_n;
            r_qk[r_wp] <= bus.job_k;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_accept && w_zero;
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    for (genvar gi = 0; gi < NCORE; gi++) begin : g_core
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state[gi] <= S_IDLE;
                r_cyc[gi]   <= '0;
                r_cm[gi]    <= '0;
                r_cn[gi]    <= '0;
                r_ck[gi]    <= '0;
                r_start[gi] <= 1'b0;
            end else begin
                r_start[gi] <= w_disp_sel[gi];
                case (r_state[gi])
                    S_IDLE: begin
                        if (w_disp_sel[gi]) begin
                            r_state[gi] <= S_START;
                            r_cyc[gi]   <= CYC_W'(1);
                            r_cm[gi]    <= r_qm[r_rp];
                            r_cn[gi]    <= r_qn[r_rp];
                            r_ck[gi]    <= r_qk[r_rp];
                        end
                    end
                    S_START: begin
                        r_state[gi] <= S_RUN;
                        r_cyc[gi]   <= (r_cyc[gi] == c_cyc_max) ? r_cyc[gi] : r_cyc[gi] + 1'b1;
                    end
                    S_RUN: begin
                        // The completing edge itself is counted.
                        r_cyc[gi] <= (r_cyc[gi] == c_cyc_max) ? r_cyc[gi] : r_cyc[gi] + 1'b1;
                        if (bus.core_done[gi]) r_state[gi] <= S_DONE;
                    end
                    S_DONE: begin
                        if (w_rep_sel[gi]) r_state[gi] <= S_IDLE;
                    end
                    default: r_state[gi] <= S_IDLE;
                endcase
            end
        end

        assign bus.core_start[gi]               = r_start[gi];
        assign bus.core_m[gi*DIM_W +: DIM_W]    = r_cm[gi];
        assign bus.core_n[gi*DIM_W +: DIM_W]    = r_cn[gi];
        assign bus.core_k[gi*DIM_W +: DIM_W]    = r_ck[gi];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done     <= 1'b0;
            r_done_id  <= '0;
            r_done_cyc <= '0;
        end else begin
            r_done     <= w_rep_any;
            r_done_id  <= w_rep_id;
            r_done_cyc <= w_rep_cyc;
        end
    end

    assign bus.job_ready   = !w_full;
    assign bus.q_count     = r_count;
    assign bus.idle        = w_empty && (&w_is_idle);
    assign bus.err_zero    = r_err;
    assign bus.done        = r_done;
    assign bus.done_id     = r_done_id;
    assign bus.done_cycles = r_done_cyc;
endmodule
`default_nettype wire

// File: tb/tb_tpu_job_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tpu_job_dispatcher
//  Purpose  : Scoreboard bench for tpu_job_dispatcher (2 cores, 4-deep FIFO).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_job_dispatcher;
    localparam int DIM_W  = 4;
    localparam int NCORE  = 2;
    localparam int QDEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tpu_job_dispatcher_if #(.DIM_W(DIM_W), .NCORE(NCORE), .CYC_W(16), .QDEPTH(QDEPTH)) bus ();
    tpu_job_dispatcher_if #(.DIM_W(DIM_W), .NCORE(NCORE), .CYC_W(4),  .QDEPTH(QDEPTH)) bus4 ();

    tpu_job_dispatcher #(.DIM_W(DIM_W), .QDEPTH(QDEPTH), .NCORE(NCORE), .CYC_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    tpu_job_dispatcher #(.DIM_W(DIM_W), .QDEPTH(QDEPTH), .NCORE(NCORE), .CYC_W(4)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct { int core; logic [3:0] m; logic [3:0] n; logic [3:0] k; } start_t;
    typedef struct { int id; int cycles; } done_t;

    start_t exp_start[$];
    done_t  exp_done[$];
    int     start_edge [NCORE];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    start_t mon_s;
    done_t  mon_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Start and completion monitor; pops the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCORE; i++) begin
                if (bus.core_start[i]) begin
                    start_edge[i] = cyc;
                    if (exp_start.size() == 0) begin
                        check_eq("unexpected_start", 32'(bus.core_start[i]), 0);
                    end else begin
                        mon_s = exp_start.pop_front();
                        check_eq("start_core", i, mon_s.core);
                        check_eq("start_m", 32'(bus.core_m[i*DIM_W +: DIM_W]), 32'(mon_s.m));
                        check_eq("start_n", 32'(bus.core_n[i*DIM_W +: DIM_W]), 32'(mon_s.n));
                        check_eq("start_k", 32'(bus.core_k[i*DIM_W +: DIM_W]), 32'(mon_s.k));
                    end
                end
            end
            if (bus.done) begin
                if (exp_done.size() == 0) begin
                    check_eq("unexpected_done", 32'(bus.done), 0);
                end else begin
                    mon_d = exp_done.pop_front();
                    check_eq("done_id", 32'(bus.done_id), mon_d.id);
                    check_eq("done_cycles", 32'(bus.done_cycles), mon_d.cycles);
                end
            end
        end
    end

    // Called at a negedge; the job is accepted on the first posedge with job_ready high.
    task automatic push_job(input logic [3:0] m, input logic [3:0] n, input logic [3:0] k,
                            input int core, input bit expect_start);
        start_t s;
        if (expect_start) begin
            s.core = core; s.m = m; s.n = n; s.k = k;
            exp_start.push_back(s);
        end
        bus.job_valid = 1'b1;
        bus.job_m = m; bus.job_n = n; bus.job_k = k;
        for (int t = 0; t < 100 && !bus.job_ready; t++) @(negedge clk);
        if (!bus.job_ready) check_eq("push_timeout", 32'(bus.job_ready), 1);
        @(negedge clk);
        bus.job_valid = 1'b0;
    endtask

    // Raises core_done for one sample; expected count = START edge .. DONE edge inclusive.
    task automatic complete(input int i);
        done_t d;
        d.id = i;
        d.cycles = cyc + 2 - start_edge[i];
        exp_done.push_back(d);
        bus.core_done[i] = 1'b1;
        @(negedge clk);
        bus.core_done[i] = 1'b0;
    endtask

    task automatic complete_both();
        done_t d;
        for (int i = 0; i < NCORE; i++) begin
            d.id = i;
            d.cycles = cyc + 2 - start_edge[i];
            exp_done.push_back(d);
        end
        bus.core_done = '1;
        @(negedge clk);
        bus.core_done = '0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100; t++) begin
            if (bus.idle && exp_done.size() == 0) break;
            @(negedge clk);
        end
        check_eq("wait_idle", 32'(bus.idle), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.job_valid  = 1'b0; bus.job_m  = '0; bus.job_n  = '0; bus.job_k  = '0; bus.core_done  = '0;
        bus4.job_valid = 1'b0; bus4.job_m = '0; bus4.job_n = '0; bus4.job_k = '0; bus4.core_done = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_job_ready", 32'(bus.job_ready), 1);
        check_eq("rst_idle", 32'(bus.idle), 1);
        check_eq("rst_q_count", 32'(bus.q_count), 0);
        check_eq("rst_core_start", 32'(bus.core_start), 0);
        check_eq("rst_core_m", 32'(bus.core_m), 0);
        check_eq("rst_done", 32'(bus.done), 0);
        check_eq("rst_done_id", 32'(bus.done_id), 0);
        check_eq("rst_done_cycles", 32'(bus.done_cycles), 0);
        check_eq("rst_err_zero", 32'(bus.err_zero), 0);
        rst = 1'b1;
        @(negedge clk);

        // Single job: start E1-E2, done sampled at E6 -> 6 cycles.
        push_job(4'd3, 4'd2, 4'd4, 0, 1'b1);
        check_eq("accept_q_count", 32'(bus.q_count), 1);
        @(negedge clk);
        check_eq("start_latency", 32'(bus.core_start), 32'h1);
        @(negedge clk);
        check_eq("start_one_cycle", 32'(bus.core_start), 0);
        repeat (3) @(negedge clk);
        complete(0);
        @(negedge clk);
        check_eq("done_latency", 32'(bus.done), 1);
        wait_idle();

        // Fill and backpressure with pointer wrap.
        push_job(4'd1, 4'd1, 4'd1, 0, 1'b1);
        push_job(4'd2, 4'd2, 4'd2, 1, 1'b1);
        push_job(4'd3, 4'd3, 4'd3, 0, 1'b1);
        push_job(4'd4, 4'd4, 4'd4, 1, 1'b1);
        push_job(4'd5, 4'd5, 4'd5, 0, 1'b1);
        push_job(4'd6, 4'd6, 4'd6, 1, 1'b1);
        check_eq("full_q_count", 32'(bus.q_count), 4);
        check_eq("full_job_ready", 32'(bus.job_ready), 0);
        fork
            push_job(4'd7, 4'd7, 4'd7, 0, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_eq("held_q_count", 32'(bus.q_count), 4);
                end
                complete(0);
            end
        join
        repeat (4) @(negedge clk);
        complete(1);
        repeat (4) @(negedge clk);
        complete(0);
        repeat (4) @(negedge clk);
        complete(1);
        repeat (4) @(negedge clk);
        complete(0);
        repeat (4) @(negedge clk);

        // Simultaneous completion: core 0 reported first, core 1 one cycle later.
        complete_both();
        @(negedge clk);
        check_eq("simul_first_id", 32'(bus.done_id), 0);
        @(negedge clk);
        check_eq("simul_second_done", 32'(bus.done), 1);
        check_eq("simul_second_id", 32'(bus.done_id), 1);
        wait_idle();

        // Zero-dimension job is consumed, flagged, never dispatched.
        push_job(4'd5, 4'd3, 4'd0, 0, 1'b0);
        check_eq("zero_err_pulse", 32'(bus.err_zero), 1);
        check_eq("zero_q_count", 32'(bus.q_count), 0);
        @(negedge clk);
        check_eq("zero_err_clear", 32'(bus.err_zero), 0);
        repeat (3) @(negedge clk);
        check_eq("zero_idle", 32'(bus.idle), 1);

        // Saturation on the 4-bit counter instance.
        bus4.job_valid = 1'b1; bus4.job_m = 4'd1; bus4.job_n = 4'd1; bus4.job_k = 4'd1;
        @(negedge clk);
        bus4.job_valid = 1'b0;
        for (int t = 0; t < 10 && !bus4.core_start[0]; t++) @(negedge clk);
        check_eq("sat_start", 32'(bus4.core_start[0]), 1);
        repeat (20) @(negedge clk);
        bus4.core_done[0] = 1'b1;
        @(negedge clk);
        bus4.core_done[0] = 1'b0;
        for (int t = 0; t < 10 && !bus4.done; t++) @(negedge clk);
        check_eq("sat_done", 32'(bus4.done), 1);
        check_eq("sat_done_id", 32'(bus4.done_id), 0);
        check_eq("sat_done_cycles", 32'(bus4.done_cycles), 15);

        // Reset while both cores run and two jobs are queued.
        push_job(4'd1, 4'd2, 4'd3, 0, 1'b1);
        push_job(4'd4, 4'd5, 4'd6, 1, 1'b1);
        push_job(4'd7, 4'd8, 4'd9, 0, 1'b1);
        push_job(4'd9, 4'd9, 4'd9, 1, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("midrun_q_count", 32'(bus.q_count), 2);
        #2;
        rst = 1'b0;
        exp_start.delete();
        #1;
        check_eq("midrun_rst_q_count", 32'(bus.q_count), 0);
        check_eq("midrun_rst_start", 32'(bus.core_start), 0);
        check_eq("midrun_rst_core_m", 32'(bus.core_m), 0);
        check_eq("midrun_rst_idle", 32'(bus.idle), 1);
        check_eq("midrun_rst_ready", 32'(bus.job_ready), 1);
        check_eq("midrun_rst_done", 32'(bus.done), 0);
        @(negedge clk);
        rst = 1'b1;
        bus.core_done = '1;
        repeat (5) @(negedge clk);
        bus.core_done = '0;
        repeat (5) @(negedge clk);
        check_eq("post_rst_idle", 32'(bus.idle), 1);

        check_eq("sb_start_empty", exp_start.size(), 0);
        check_eq("sb_done_empty", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
